// File: rtl/i2s_mic_capture.sv
// I2S master receiver for a stereo MEMS microphone pair: generates SCK/WS from clkin,
// deserialises SD into left/right samples and hands frames out over valid/ready.
module i2s_mic_capture #(
    parameter int CLK_DIV     = 10,
    parameter int SAMPLE_BITS = 24,
    parameter int SLOT_BITS   = 32
) (
    input  logic                   clkin,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   i2s_sd,
    output logic                   i2s_sck,
    output logic                   i2s_ws,
    output logic [SAMPLE_BITS-1:0] left_data,
    output logic [SAMPLE_BITS-1:0] right_data,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] L_FIRST    = BIT_W'(1);
    localparam logic [BIT_W-1:0] L_LAST     = BIT_W'(SAMPLE_BITS);
    localparam logic [BIT_W-1:0] R_FIRST    = BIT_W'(SLOT_BITS + 1);
    localparam logic [BIT_W-1:0] R_LAST     = BIT_W'(SLOT_BITS + SAMPLE_BITS);

    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   sd_q;
    logic [SAMPLE_BITS-1:0] left_sr;
    logic [SAMPLE_BITS-1:0] right_sr;

    logic             div_tc;
    logic             sck_rise;
    logic             sck_fall;
    logic             frame_done;
    logic             shift_l;
    logic             shift_r;
    logic             accept;
    logic [BIT_W-1:0] bit_nxt;

    always_comb begin
        div_tc     = enable && (div_cnt == DIV_LAST);
        sck_rise   = div_tc && !i2s_sck;
        sck_fall   = div_tc && i2s_sck;
        frame_done = sck_fall && (bit_cnt == BIT_LAST);
        bit_nxt    = frame_done ? '0 : bit_cnt + BIT_W'(1);
        // Slot bit 0 is the one-bit I2S delay after WS; bits past SAMPLE_BITS are padding.
        shift_l    = sck_rise && (bit_cnt >= L_FIRST) && (bit_cnt <= L_LAST);
        shift_r    = sck_rise && (bit_cnt >= R_FIRST) && (bit_cnt <= R_LAST);
        accept     = sample_valid && sample_ready;
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            sd_q         <= 1'b0;
            left_sr      <= '0;
            right_sr     <= '0;
            i2s_sck      <= 1'b0;
            i2s_ws       <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sd_q <= i2s_sd;

            if (!enable) begin
                div_cnt  <= '0;
                bit_cnt  <= '0;
                i2s_sck  <= 1'b0;
                i2s_ws   <= 1'b0;
                left_sr  <= '0;
                right_sr <= '0;
            end else begin
                div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
                if (div_tc) begin
                    i2s_sck <= ~i2s_sck;
                end
                if (sck_fall) begin
                    bit_cnt <= bit_nxt;
                    i2s_ws  <= (bit_nxt >= SLOT_START);
                end
                if (shift_l) begin
                    left_sr <= {left_sr[SAMPLE_BITS-2:0], sd_q};
                end
                if (shift_r) begin
                    right_sr <= {right_sr[SAMPLE_BITS-2:0], sd_q};
                end
            end

            // A completing frame wins over an accept on the same edge; valid then stays high.
            if (frame_done) begin
                left_data    <= left_sr;
                right_data   <= right_sr;
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2s_mic_capture.md
Name: i2s_mic_capture

Overview:
- I2S master receiver for the MEMS microphone pair on the acoustic camera.
- Runs on the 60 MHz clock from the PLL stage. Generates the I2S bit clock (SCK) and word select (WS), and deserialises the SD line into 24-bit left/right samples.
- Hands each stereo frame downstream over a valid/ready interface, with sticky overrun detection.

Parameters:
- CLK_DIV, 10: clkin cycles per SCK half-period. Legal range >= 2. SCK = 60 MHz / (2*CLK_DIV) = 3 MHz at the default.
- SAMPLE_BITS, 24: bits captured per channel, MSB first. Must be <= 31.
- SLOT_BITS, 32: SCK periods per channel slot. A frame is 2*SLOT_BITS periods (46.875 kHz at defaults).

Ports:
- clkin  in  1  system clock, 60 MHz from the PLL.
- reset  in  1  synchronous, active-high.
- enable  in  1  level; 1 = run the I2S clocks and capture.
- i2s_sd  in  1  serial data from the microphones.
- i2s_sck  out  1  bit clock.
- i2s_ws  out  1  word select; 0 = left, 1 = right.
- left_data  out  SAMPLE_BITS  last completed left sample.
- right_data  out  SAMPLE_BITS  last completed right sample.
- sample_valid  out  1  frame available.
- sample_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky: an unaccepted frame was overwritten.

Behaviour:
- Clock and reset: single clock domain (clkin), synchronous active-high reset. On reset, all outputs are 0 and all counters, shift registers and sd_q are 0.
- Divider: div_cnt runs 0..CLK_DIV-1 while enable=1. On the edge where div_cnt==CLK_DIV-1, SCK toggles and div_cnt returns to 0.
- Bit counter: bit_cnt runs 0..2*SLOT_BITS-1 and increments (wrapping) on each SCK high->low edge.
- Word select: i2s_ws = (bit_cnt >= SLOT_BITS) and is registered together with bit_cnt, so it only changes on SCK falling edges.
- Input register: i2s_sd is registered once into sd_q.
- Sampling: on the clkin edge where SCK goes low->high, sd_q is shifted into the active channel's shift register, MSB first, when:
  - left: bit_cnt in 1..SAMPLE_BITS
  - right: bit_cnt in SLOT_BITS+1..SLOT_BITS+SAMPLE_BITS
  This gives the standard I2S one-bit delay after WS. Slot bit 0 and bits beyond SAMPLE_BITS are ignored.
- Frame completion: on the SCK falling edge where bit_cnt wraps from 2*SLOT_BITS-1 to 0, both shift registers are copied to left_data/right_data and sample_valid is set to 1.
- Startup latency: the first sample_valid occurs 2*CLK_DIV*2*SLOT_BITS clkin edges after the first edge with enable=1 (1280 at defaults).
- Handshake: the transfer happens on a clkin edge with sample_valid=1 and sample_ready=1; sample_valid clears on the next cycle unless a frame completes on that same edge.
  - Data is stable while valid=1 and ready=0.
  - Accept and frame completion on the same edge: new data loads, valid stays 1, overrun unchanged.
  - Frame completion while valid=1 and ready=0: data is overwritten, valid stays 1, overrun is set to 1.
  - overrun clears only on reset.
- Enable low: on any edge with enable=0, div_cnt, bit_cnt and the shift registers return to 0, and i2s_sck and i2s_ws go to 0.
  - Any partial frame is discarded; no frame completion occurs.
  - left_data/right_data, sample_valid and overrun hold, and the handshake continues to operate.
- Enable high again: restarts at bit_cnt=0 with SCK low.
- Reset mid-frame: immediate return to the reset state. No frame completion occurs on the reset edge.

Test Plan:
- Basic capture. Stimulus: reset, then enable=1 with a bench I2S mic model (shifts on SCK falling edge) driving left=0xA5A5A5, right=0x5A5A5A, slot filler bits=1. Required response: SCK period 20 clkin; WS toggles every 32 SCK; first sample_valid at edge 1280; left_data=0xA5A5A5, right_data=0x5A5A5A; filler bits ignored.
- Backpressure and overrun. Stimulus: sample_ready=0 across two frames (0x111111/0x222222, then 0x333333/0x444444). Required response: after frame 2, outputs are 0x333333/0x444444, valid=1, overrun=1; overrun stays 1 after a later accept.
- Same-edge accept. Stimulus: pulse sample_ready exactly on a frame-completion edge while valid=1. Required response: valid stays 1, new data is loaded, overrun=0.
- Enable drop. Stimulus: drop enable at bit_cnt=40, re-enable 100 cycles later. Required response: SCK=WS=0 while disabled; no spurious valid; the next frame completes 1280 edges after re-enable with correct data.
- Reset mid-frame. Stimulus: assert reset with valid=1 mid-frame. Required response: all outputs 0 on the next cycle; capture resumes correctly after release.
- Parameter variant. Stimulus: CLK_DIV=2, SAMPLE_BITS=16, left=0x8001, right=0x7FFE. Required response: SCK period 4 clkin; first valid at edge 256; data matches.
